mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst_n  in  1  asynchronous, active-low reset.
REQ-002 SHALL have ports: if_req  in  1  fetch request; if_addr  in  32  fetch word address; if_rdata  out  32  fetch data; if_ready  out  1  fetch done pulse.
REQ-003 SHALL have ports: dm_req  in  1  load/store request; dm_we  in  1  store; dm_addr  in  32; dm_wdata  in  32; dm_be  in  4  byte enables; dm_rdata  out  32; dm_ready  out  1  done pulse.
REQ-004 SHALL have ports: mem_req  out  1; mem_we  out  1; mem_addr  out  32; mem_wdata  out  32; mem_be  out  4; mem_gnt  in  1  address accepted; mem_rvalid  in  1  response (read data or write ack); mem_rdata  in  32.
REQ-005 SHALL have ports: stallF_arb  out  1  fetch stall to hazard logic; stallM_arb  out  1  memory-stage stall to hazard logic.

Function
REQ-006 SHALL share one memory port between fetch and data requesters, one outstanding transaction maximum.
REQ-007 SHALL implement FSM states IDLE, REQ, RSP.
REQ-008 IDLE: if any request is high, SHALL select a winner, latch its we/addr/wdata/be and an owner bit into registers, and go to REQ next cycle; otherwise stay IDLE.
REQ-009 Fetch transactions SHALL drive mem_we=0 and mem_be=4'hF.
REQ-010 REQ: mem_req=1 with latched fields; on mem_gnt=1, go to RSP next cycle; fields SHALL stay stable while mem_req=1 and mem_gnt=0.
REQ-011 RSP: mem_req=0; on mem_rvalid=1, pulse the owner's ready for that one cycle, drive owner's rdata=mem_rdata combinationally, go to IDLE.
REQ-012 Default arbitration SHALL be fixed priority: dm over if (the older instruction wins).
REQ-013 If the owner's req is low when mem_rvalid arrives (flushed fetch), the response SHALL be dropped: no ready pulse.
REQ-014 mem_rvalid in IDLE or REQ SHALL be ignored.
REQ-015 stallF_arb = if_req & ~if_ready; stallM_arb = dm_req & ~dm_ready (combinational).
REQ-016 Minimum latency: request seen at cycle 0, mem_req at cycle 1, gnt at cycle 1, rvalid at cycle 2 -> ready at cycle 2; back-to-back transactions SHALL have one IDLE cycle between them.
REQ-017 if_rdata/dm_rdata SHALL be 32'h0 when not the ready owner.

Reset
REQ-018 rst_n low SHALL force state IDLE, owner=fetch, latched fields=0, all outputs 0, immediately and regardless of clk.
REQ-019 Reset mid-transaction SHALL abandon it; a late mem_rvalid after reset SHALL be ignored per REQ-014.

Configuration
REQ-020 With MEM_ARB_RR_EN defined, arbitration SHALL be round-robin: on simultaneous requests, the requester not granted last wins; the last-grant bit resets to fetch.
REQ-021 Without MEM_ARB_RR_EN, arbitration SHALL be fixed priority per REQ-012, with no last-grant register.

Structure
REQ-022 FSM state enum (2 bits), owner encoding and ADDR_W/DATA_W=32 constants SHALL reside in shared package core_pkg.
REQ-023 Winner selection SHALL be a sub-module mem_arb_sel (req vectors, last-grant in; one-hot grant out); the FSM and registers SHALL stay in mem_port_arbiter.

Verification
REQ-024 Fetch alone, if_addr=32'h100, gnt same cycle, rvalid next with rdata=32'h00500093 -> mem_addr=32'h100, mem_we=0, if_ready pulse with that data at cycle 2, stallF_arb low from cycle 2.
REQ-025 if_req and dm_req (store addr 32'h2000, wdata 32'hDEADBEEF, be 4'h3) raised together -> store issued first, fetch issued after one IDLE cycle; under MEM_ARB_RR_EN the second simultaneous pair goes to fetch first.
REQ-026 gnt held low 3 cycles in REQ -> mem_req and fields stable for all 4 cycles, stallM_arb high throughout.
REQ-027 if_req dropped while in RSP, then rvalid -> no if_ready pulse, FSM returns to IDLE.
REQ-028 rst_n asserted in RSP, released, then stray mem_rvalid=1 -> no ready pulse, all outputs 0, state IDLE.
REQ-029 Continuous dm_req with fixed priority -> fetch starves (stallF_arb stays high); with MEM_ARB_RR_EN, grants alternate dm/if.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions for the memory-port arbiter: bus widths, the
// arbiter FSM state encoding, owner encoding and request-vector bit positions.
// Build option: MEM_ARB_RR_EN selects round-robin arbitration (default: fixed
// priority, data side over fetch side).
package core_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  // Bit positions inside the two-entry request / grant vectors.
  localparam int REQ_IF = 0;
  localparam int REQ_DM = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  // Map a one-hot grant vector to the owner encoding (fetch when no grant).
  function automatic owner_e grant_to_owner(input logic [1:0] gnt);
    return gnt[REQ_DM] ? OWN_DM : OWN_IF;
  endfunction

endpackage

// File: rtl/mem_arb_sel.sv
// Winner selection between the fetch and data requesters of the shared
// memory port. Produces a one-hot grant (or zero when nobody requests).
// Build option: MEM_ARB_RR_EN -- when defined, simultaneous requests go to the
// requester that did not win last time; otherwise the data side always wins.
module mem_arb_sel
  import core_pkg::*;
(
  input  logic [1:0] req_i,
  input  owner_e     last_gnt_i,
  output logic [1:0] gnt_o
);

  // Pick at most one requester each cycle.
  always_comb begin
    gnt_o = 2'b00;
`ifdef MEM_ARB_RR_EN
    if (req_i[REQ_IF] && req_i[REQ_DM]) begin
      if (last_gnt_i == OWN_DM) begin
        gnt_o[REQ_IF] = 1'b1;
      end else begin
        gnt_o[REQ_DM] = 1'b1;
      end
    end else begin
      gnt_o = req_i;
    end
`else
    // The load/store belongs to the older instruction, so it goes first.
    if (req_i[REQ_DM]) begin
      gnt_o[REQ_DM] = 1'b1;
    end else if (req_i[REQ_IF]) begin
      gnt_o[REQ_IF] = 1'b1;
    end
`endif
  end

`ifndef MEM_ARB_RR_EN
  // Fixed priority has no use for the history input.
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt_i;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store with
// at most one outstanding transaction (IDLE -> REQ -> RSP -> IDLE).
// The winning request is captured in IDLE, presented while in REQ until the
// memory grants it, and the response is routed back to the owner in RSP.
// A response whose owner has meanwhile dropped its request (e.g. a flushed
// fetch) is silently discarded.
// Build option: MEM_ARB_RR_EN -- round-robin arbitration with a last-grant
// register; without it, fixed priority (data over fetch) and no history.
module mem_port_arbiter
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  // fetch side
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  // data side
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [BE_W-1:0]   dm_be,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  // memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  // hazard unit
  output logic              stallF_arb,
  output logic              stallM_arb
);

  arb_state_e        state_q;
  owner_e            owner_q;
  logic              mem_req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;

  logic [1:0]        req_vec;
  logic [1:0]        gnt;
  owner_e            last_gnt;

  owner_e            owner_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic [BE_W-1:0]   be_d;

  logic              rsp_hit;

  assign req_vec = {dm_req, if_req};

`ifdef MEM_ARB_RR_EN
  owner_e last_q;
  assign last_gnt = last_q;
`else
  assign last_gnt = OWN_IF;
`endif

  mem_arb_sel u_sel (
    .req_i      (req_vec),
    .last_gnt_i (last_gnt),
    .gnt_o      (gnt)
  );

  // Fields of the winning requester; a fetch is always a full-word read.
  always_comb begin
    owner_d = grant_to_owner(gnt);
    we_d    = 1'b0;
    addr_d  = if_addr;
    wdata_d = '0;
    be_d    = '1;
    if (gnt[REQ_DM]) begin
      we_d    = dm_we;
      addr_d  = dm_addr;
      wdata_d = dm_wdata;
      be_d    = dm_be;
    end
  end

  // Transaction FSM with registered memory-port fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_IF;
      mem_req_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
`ifdef MEM_ARB_RR_EN
      last_q    <= OWN_IF;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|gnt) begin
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            mem_req_q <= 1'b1;
            state_q   <= ST_REQ;
`ifdef MEM_ARB_RR_EN
            last_q    <= owner_d;
`endif
          end
        end
        ST_REQ: begin
          // Fields are held untouched until the memory accepts them.
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (mem_rvalid) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  // Only a response in RSP counts; strays in IDLE/REQ are ignored.
  assign rsp_hit  = (state_q == ST_RSP) && mem_rvalid;
  assign if_ready = rsp_hit && (owner_q == OWN_IF) && if_req;
  assign dm_ready = rsp_hit && (owner_q == OWN_DM) && dm_req;
  assign if_rdata = if_ready ? mem_rdata : '0;
  assign dm_rdata = dm_ready ? mem_rdata : '0;

  assign mem_req   = mem_req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

  assign stallF_arb = if_req & ~if_ready;
  assign stallM_arb = dm_req & ~dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge.
// Build option MEM_ARB_RR_EN switches the arbitration expectations.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stallF_arb;
  logic        stallM_arb;

  int   checks   = 0;
  int   failures = 0;
  logic exp_dm;

  mem_port_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_ready   (if_ready),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_be      (dm_be),
    .dm_rdata   (dm_rdata),
    .dm_ready   (dm_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .stallF_arb (stallF_arb),
    .stallM_arb (stallM_arb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // reset state
    #2;
    chk1 ("rst_mem_req", mem_req, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk1 ("rst_if_ready", if_ready, 1'b0);
    chk1 ("rst_dm_ready", dm_ready, 1'b0);
    chk32("rst_if_rdata", if_rdata, 32'h0);
    nxt();
    rst_n = 1'b1;

    // fetch alone, minimum latency
    if_req = 1'b1; if_addr = 32'h100;
    #4; chk1("A_c0_stallF", stallF_arb, 1'b1); chk1("A_c0_mem_req", mem_req, 1'b0);
    nxt(); mem_gnt = 1'b1;
    #4; chk1("A_c1_mem_req", mem_req, 1'b1); chk32("A_c1_addr", mem_addr, 32'h100);
    chk1("A_c1_we", mem_we, 1'b0); chk32("A_c1_be", {28'h0, mem_be}, 32'hF);
    nxt(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00500093;
    #4; chk1("A_c2_if_ready", if_ready, 1'b1); chk32("A_c2_if_rdata", if_rdata, 32'h00500093);
    chk1("A_c2_stallF", stallF_arb, 1'b0); chk1("A_c2_mem_req", mem_req, 1'b0);
    nxt(); if_req = 1'b0; mem_rvalid = 1'b0;
    #4; chk1("A_c3_if_ready", if_ready, 1'b0); chk32("A_c3_if_rdata", if_rdata, 32'h0);

    // simultaneous store + fetch: store first, one idle cycle, then fetch
    nxt();
    if_req = 1'b1; if_addr = 32'h104;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF; dm_be = 4'h3;
    #4; chk1("B_stallF", stallF_arb, 1'b1); chk1("B_stallM", stallM_arb, 1'b1);
    nxt(); mem_gnt = 1'b1;
    #4; chk1("B_st_req", mem_req, 1'b1); chk32("B_st_addr", mem_addr, 32'h2000);
    chk1("B_st_we", mem_we, 1'b1); chk32("B_st_wdata", mem_wdata, 32'hDEADBEEF);
    chk32("B_st_be", {28'h0, mem_be}, 32'h3);
    nxt(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0;
    #4; chk1("B_st_dm_ready", dm_ready, 1'b1); chk1("B_st_if_ready", if_ready, 1'b0);
    chk1("B_st_stallM", stallM_arb, 1'b0);
    nxt(); dm_req = 1'b0; dm_we = 1'b0; mem_rvalid = 1'b0;
    #4; chk1("B_gap_mem_req", mem_req, 1'b0);
    nxt(); mem_gnt = 1'b1;
    #4; chk1("B_f_req", mem_req, 1'b1); chk32("B_f_addr", mem_addr, 32'h104);
    chk1("B_f_we", mem_we, 1'b0); chk32("B_f_be", {28'h0, mem_be}, 32'hF);
    nxt(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    #4; chk1("B_f_if_ready", if_ready, 1'b1); chk32("B_f_if_rdata", if_rdata, 32'h12345678);
    chk32("B_f_dm_rdata", dm_rdata, 32'h0);
    nxt(); if_req = 1'b0; mem_rvalid = 1'b0;

    // load with grant withheld 3 cycles; stray rvalid while in REQ
    nxt();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000; dm_wdata = 32'h0; dm_be = 4'hF;
    #4;
    nxt();
    for (int i = 0; i < 4; i++) begin
      mem_gnt = (i == 3);
      mem_rvalid = (i == 1);
      dm_addr = 32'hFFFF0000 + 32'(i);
      #4;
      chk1 ("C_mem_req", mem_req, 1'b1);
      chk32("C_addr", mem_addr, 32'h3000);
      chk1 ("C_we", mem_we, 1'b0);
      chk1 ("C_stallM", stallM_arb, 1'b1);
      chk1 ("C_dm_ready", dm_ready, 1'b0);
      nxt();
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    #4; chk1("C_dm_ready_rsp", dm_ready, 1'b1); chk32("C_dm_rdata", dm_rdata, 32'hCAFEF00D);
    nxt(); dm_req = 1'b0; mem_rvalid = 1'b0;

    // flushed fetch: response dropped, FSM back to IDLE
    nxt(); if_req = 1'b1; if_addr = 32'h200;
    #4;
    nxt(); mem_gnt = 1'b1;
    #4; chk32("D_addr", mem_addr, 32'h200);
    nxt(); mem_gnt = 1'b0; if_req = 1'b0;
    #4; chk1("D_rsp_mem_req", mem_req, 1'b0); chk1("D_stallF", stallF_arb, 1'b0);
    nxt(); mem_rvalid = 1'b1; mem_rdata = 32'hAAAA5555;
    #4; chk1("D_if_ready", if_ready, 1'b0); chk32("D_if_rdata", if_rdata, 32'h0);
    nxt(); mem_rvalid = 1'b0;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h4000; dm_wdata = 32'h11223344; dm_be = 4'hC;
    #4; chk1("D_idle_mem_req", mem_req, 1'b0);
    nxt(); mem_gnt = 1'b1;
    #4; chk1("D_next_req", mem_req, 1'b1); chk32("D_next_addr", mem_addr, 32'h4000);
    chk32("D_next_be", {28'h0, mem_be}, 32'hC);
    nxt(); mem_gnt = 1'b0; mem_rvalid = 1'b1;
    #4; chk1("D_next_dm_ready", dm_ready, 1'b1);
    nxt(); dm_req = 1'b0; dm_we = 1'b0; mem_rvalid = 1'b0;

    // reset in RSP, then a stray response
    nxt(); if_req = 1'b1; if_addr = 32'h300;
    #4;
    nxt(); mem_gnt = 1'b1;
    #4;
    nxt(); mem_gnt = 1'b0; if_req = 1'b0;
    #2; rst_n = 1'b0;
    #1; chk1("E_rst_mem_req", mem_req, 1'b0); chk32("E_rst_addr", mem_addr, 32'h0);
    chk32("E_rst_be", {28'h0, mem_be}, 32'h0); chk1("E_rst_we", mem_we, 1'b0);
    nxt(); rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    #4; chk1("E_if_ready", if_ready, 1'b0); chk1("E_dm_ready", dm_ready, 1'b0);
    chk32("E_if_rdata", if_rdata, 32'h0); chk32("E_dm_rdata", dm_rdata, 32'h0);
    chk1("E_mem_req", mem_req, 1'b0); chk1("E_stallF", stallF_arb, 1'b0);
    chk1("E_stallM", stallM_arb, 1'b0);
    nxt(); if_req = 1'b1; if_addr = 32'h500;
    #4; chk1("E_idle_if_ready", if_ready, 1'b0); chk32("E_idle_if_rdata", if_rdata, 32'h0);
    nxt(); mem_gnt = 1'b1;
    #4; chk1("E_req_if_ready", if_ready, 1'b0); chk1("E_req_mem_req", mem_req, 1'b1);
    chk32("E_req_addr", mem_addr, 32'h500);
    nxt(); mem_gnt = 1'b0; mem_rdata = 32'h0BADC0DE;
    #4; chk1("E_rsp_if_ready", if_ready, 1'b1); chk32("E_rsp_if_rdata", if_rdata, 32'h0BADC0DE);
    nxt(); if_req = 1'b0; mem_rvalid = 1'b0;

    // both requesters held continuously
    nxt();
    if_req = 1'b1; if_addr = 32'h600;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h5000; dm_be = 4'hF;
    for (int k = 0; k < 3; k++) begin
      exp_dm = RR ? (k != 1) : 1'b1;
      mem_rvalid = 1'b0;
      #4; chk1("F_gap_mem_req", mem_req, 1'b0);
      nxt(); mem_gnt = 1'b1;
      #4; chk32("F_addr", mem_addr, exp_dm ? 32'h5000 : 32'h600);
      nxt(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'(k);
      #4; chk1("F_dm_ready", dm_ready, exp_dm); chk1("F_if_ready", if_ready, ~exp_dm);
      chk1("F_stallF", stallF_arb, exp_dm);
      nxt();
    end
    mem_rvalid = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    #4; chk1("F_end_mem_req", mem_req, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
